out_sequencer: RTL and testbench

OUT_SEQUENCER -- requirements
Module: out_sequencer

---
 rtl/out_pkg.sv | 29 ++
 rtl/out_sequencer_if.sv | 22 ++
 rtl/button_debounce.sv | 47 ++++
 rtl/out_sequencer.sv | 108 ++++++++++
 tb/tb_out_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/out_pkg.sv
// Shared types and constants for the output sequencer: FSM states, the
// double-dabble geometry and the blank-digit code.
package out_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONVERT      = 2'd1,
    WAIT_RELEASE = 2'd2,
    WAIT_PRESS   = 2'd3
  } state_t;

  localparam int BCD_DIGITS = 5;
  localparam int BIN_BITS   = 16;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // One double-dabble correction step: every BCD nibble >= 5 gets +3 so
  // that the following left shift carries correctly into the next digit.
  function automatic logic [4*BCD_DIGITS-1:0] dabble_adjust(
    input logic [4*BCD_DIGITS-1:0] acc
  );
    logic [4*BCD_DIGITS-1:0] r;
    r = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_sequencer_if.sv
// CPU-facing bus of the output sequencer: write strobe and value in,
// BCD display, overflow flag and stall request out.
interface out_sequencer_if;
  logic        write_enable;
  logic [31:0] input_value;
  logic [3:0]  sevn_seg1;
  logic [3:0]  sevn_seg2;
  logic [3:0]  sevn_seg3;
  logic [3:0]  sevn_seg4;
  logic        overflow;
  logic        halt_from_output;

  modport master (
    output write_enable, input_value,
    input  sevn_seg1, sevn_seg2, sevn_seg3, sevn_seg4, overflow, halt_from_output
  );

  modport slave (
    input  write_enable, input_value,
    output sevn_seg1, sevn_seg2, sevn_seg3, sevn_seg4, overflow, halt_from_output
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for the
// raw acknowledge button. The level only flips after DEBOUNCE_CYCLES
// synchronized samples in a row disagree with it.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_p1 != level) begin
      if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: rtl/out_sequencer.sv
// Output sequencer: accepts a CPU write, converts the low 16 bits to BCD
// by double dabble (one bit per cycle), shows the result on four digits and
// stalls the CPU until the user acknowledges with a fresh button press.
module out_sequencer
  import out_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              button,
  out_sequencer_if.slave    bus
);

  state_t                  state;
  state_t                  next_state;
  logic [BIN_BITS-1:0]     capture;
  logic [4*BCD_DIGITS-1:0] acc;
  logic [4*BCD_DIGITS-1:0] acc_adj;
  logic [4*BCD_DIGITS-1:0] acc_next;
  logic [3:0]              bit_cnt;
  logic                    last_bit;
  logic                    btn_level;
  logic [3:0]              disp_seg1;
  logic [3:0]              disp_seg2;
  logic [3:0]              disp_seg3;
  logic [3:0]              disp_seg4;
  logic                    disp_ovf;
  logic                    unused_hi;

  // Upper half of the CPU word carries nothing for the display.
  assign unused_hi = ^bus.input_value[31:16];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (button),
    .level   (btn_level)
  );

  assign last_bit = (bit_cnt == 4'(BIN_BITS - 1));

  // Double-dabble step: correct nibbles, then shift in the next MSB.
  always_comb begin
    acc_adj  = dabble_adjust(acc);
    acc_next = {acc_adj[4*BCD_DIGITS-2:0], capture[BIN_BITS-1]};
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; writes are only looked at while idle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:         if (bus.write_enable) next_state = CONVERT;
      CONVERT:      if (last_bit)         next_state = WAIT_RELEASE;
      WAIT_RELEASE: if (!btn_level)       next_state = WAIT_PRESS;
      WAIT_PRESS:   if (btn_level)        next_state = IDLE;
      default:                            next_state = IDLE;
    endcase
  end

  // Conversion datapath and display registers; the display only changes
  // on the edge that completes the 16th conversion step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      capture   <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      disp_seg1 <= BLANK_DIGIT;
      disp_seg2 <= BLANK_DIGIT;
      disp_seg3 <= BLANK_DIGIT;
      disp_seg4 <= BLANK_DIGIT;
      disp_ovf  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.write_enable) begin
        capture <= bus.input_value[BIN_BITS-1:0];
        acc     <= '0;
        bit_cnt <= '0;
      end
    end else if (state == CONVERT) begin
      acc     <= acc_next;
      capture <= capture << 1;
      bit_cnt <= bit_cnt + 4'd1;
      if (last_bit) begin
        disp_seg1 <= acc_next[3:0];
        disp_seg2 <= acc_next[7:4];
        disp_seg3 <= acc_next[11:8];
        disp_seg4 <= acc_next[15:12];
        disp_ovf  <= (acc_next[19:16] != 4'd0);
      end
    end
  end

  assign bus.sevn_seg1        = disp_seg1;
  assign bus.sevn_seg2        = disp_seg2;
  assign bus.sevn_seg3        = disp_seg3;
  assign bus.sevn_seg4        = disp_seg4;
  assign bus.overflow         = disp_ovf;
  assign bus.halt_from_output = (state != IDLE);

endmodule

// File: tb/tb_out_sequencer.sv
// Bench for out_sequencer: expected displays are queued when a write is
// driven and popped when the conversion completes.
module tb_out_sequencer;

  typedef struct packed {
    logic [3:0] d4;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic       ovf;
  } disp_t;

  logic clock;
  logic reset_n;
  logic button;

  out_sequencer_if bus ();

  out_sequencer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (button),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_chk  = 0;
  int    n_pass = 0;
  disp_t sb_q[$];
  disp_t last_disp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic disp_t model(input int v);
    disp_t d;
    d.d1  = 4'(v % 10);
    d.d2  = 4'((v / 10) % 10);
    d.d3  = 4'((v / 100) % 10);
    d.d4  = 4'((v / 1000) % 10);
    d.ovf = (v > 9999);
    return d;
  endfunction

  function automatic disp_t blank_disp();
    disp_t d;
    d.d1 = 4'hF; d.d2 = 4'hF; d.d3 = 4'hF; d.d4 = 4'hF; d.ovf = 1'b0;
    return d;
  endfunction

  task automatic check_disp(input string tag, input disp_t e);
    chk({tag, "_seg1"}, bus.sevn_seg1, e.d1);
    chk({tag, "_seg2"}, bus.sevn_seg2, e.d2);
    chk({tag, "_seg3"}, bus.sevn_seg3, e.d3);
    chk({tag, "_seg4"}, bus.sevn_seg4, e.d4);
    chk({tag, "_ovf"},  bus.overflow,  e.ovf);
  endtask

  // One-cycle write; the DUT is expected to accept it on this edge.
  task automatic write_value(input int v);
    @(negedge clock);
    bus.write_enable = 1'b1;
    bus.input_value  = v;
    @(posedge clock);
    #1;
    bus.write_enable = 1'b0;
    bus.input_value  = $urandom;
    sb_q.push_back(model(v));
    chk("halt_rise", bus.halt_from_output, 1'b1);
  endtask

  // Wait out the remaining conversion edges; display must hold until the
  // 16th edge, then match the queued expectation.
  task automatic finish_convert(input int used);
    disp_t e;
    repeat (15 - used) @(posedge clock);
    #1;
    chk("halt_mid", bus.halt_from_output, 1'b1);
    check_disp("hold", last_disp);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check_disp("conv", e);
      last_disp = e;
    end
    chk("halt_after_conv", bus.halt_from_output, 1'b1);
  endtask

  // Press the button for len edges; report the edge halt first falls
  // (0 if it never does within the window).
  task automatic press(input int len, input int expect_fall, input string tag);
    int fall;
    fall = 0;
    @(negedge clock);
    button = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (i == len) button = 1'b0;
      if (!bus.halt_from_output && fall == 0) fall = i;
    end
    chk(tag, fall, expect_fall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    button           = 1'b0;
    bus.write_enable = 1'b0;
    bus.input_value  = '0;
    last_disp        = blank_disp();
    repeat (3) @(posedge clock);
    #1;
    check_disp("reset", blank_disp());
    chk("reset_halt", bus.halt_from_output, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(posedge clock);

    // 1234 with the button released, then short and long presses.
    write_value(1234);
    finish_convert(0);
    repeat (3) @(posedge clock);
    press(3, 0, "short_pulse_no_fall");
    press(6, 7, "long_pulse_fall");
    chk("idle_halt", bus.halt_from_output, 1'b0);

    // Overflow and zero.
    write_value(65535);
    finish_convert(0);
    press(6, 7, "ack_65535");
    write_value(0);
    finish_convert(0);
    press(6, 7, "ack_0");

    // Button held from before the write: release then fresh press needed.
    @(negedge clock);
    button = 1'b1;
    repeat (10) @(posedge clock);
    write_value(42);
    finish_convert(0);
    repeat (10) @(posedge clock);
    #1;
    chk("held_halt", bus.halt_from_output, 1'b1);
    @(negedge clock);
    button = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("released_halt", bus.halt_from_output, 1'b1);
    check_disp("held", last_disp);
    press(6, 7, "ack_42");

    // Write during conversion is ignored.
    write_value(1234);
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus.write_enable = 1'b1;
    bus.input_value  = 5678;
    @(posedge clock);
    #1;
    bus.write_enable = 1'b0;
    finish_convert(6);
    press(6, 7, "ack_1234b");

    // Reset in the middle of converting 9999.
    write_value(9999);
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_disp("midreset", blank_disp());
    chk("midreset_halt", bus.halt_from_output, 1'b0);
    sb_q.delete();
    last_disp = blank_disp();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    write_value(7);
    finish_convert(0);
    press(6, 7, "ack_7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
